// File: rtl/aes_dec_pkg.sv
// Shared AES-128 inverse-cipher types, sizes and GF(2^8) helpers.
// Latency: none; this file holds declarations and pure functions only.
// Backpressure: not applicable.
package aes_dec_pkg;

    localparam int NR       = 10;
    localparam int BLK_W    = 128;
    localparam int RK_IDX_W = 4;

    localparam logic [RK_IDX_W-1:0] RK_LAST = RK_IDX_W'(NR);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } aes_dec_state_e;

    // Entry 0 sits in the top byte, so entry b lives at bit offset 8*(255-b).
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
                gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
                gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
                gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless is_final.
// Latency: combinational, zero cycles.
// Backpressure: not applicable.
module aes_inv_round
    import aes_dec_pkg::*;
(
    input  logic [BLK_W-1:0] i_state,
    input  logic [BLK_W-1:0] i_rk,
    input  logic             is_final,
    output logic [BLK_W-1:0] o_state
);

    logic [BLK_W-1:0] w_sr;
    logic [BLK_W-1:0] w_sb;
    logic [BLK_W-1:0] w_ark;
    logic [BLK_W-1:0] w_mix;

    inv_shift_rows u_inv_shift_rows (
        .i_state (i_state),
        .o_state (w_sr)
    );

    for (genvar n = 0; n < 16; n++) begin : g_sub
        assign w_sb[127-8*n -: 8] = inv_sbox(w_sr[127-8*n -: 8]);
    end

    assign w_ark = w_sb ^ i_rk;

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign w_mix[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
    end

    assign o_state = is_final ? w_ark : w_mix;

endmodule

// File: rtl/inv_shift_rows.sv
// AES InvShiftRows: row r of the column-major state rotates right by r bytes.
// Latency: combinational, zero cycles.
// Backpressure: not applicable (pure wiring).
module inv_shift_rows (
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            assign o_state[127-8*(4*c+r) -: 8] = i_state[127-8*SRC -: 8];
        end
    end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// AES-128 iterative decryptor controller, one round per cycle; optional blk_cnt via AES_DEC_BLK_CNT_EN.
// Latency: out_valid is high in the 11th cycle after the accept cycle; 12-cycle minimum block period.
// Backpressure: DONE holds out_data until out_ready; in_ready is low outside IDLE.
module aes_inv_round_ctrl
    import aes_dec_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLK_W-1:0]    in_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [BLK_W-1:0]    rk_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLK_W-1:0]    out_data,
    output logic                busy
`ifdef AES_DEC_BLK_CNT_EN
    ,
    output logic [31:0]         blk_cnt
`endif
);

    aes_dec_state_e        r_fsm;
    logic [3:0]            r_round;
    logic [BLK_W-1:0]      r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;
    logic [RK_IDX_W-1:0]   r_rk_idx;
    logic [BLK_W-1:0]      w_round_out;

    aes_inv_round u_aes_inv_round (
        .i_state  (r_state),
        .i_rk     (rk_data),
        .is_final (r_fsm == FINAL),
        .o_state  (w_round_out)
    );

    // rk_idx is registered one state ahead so the key matches the state it is used in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_round     <= 4'd0;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rk_idx    <= RK_LAST;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_state    <= in_data ^ rk_data;
                        r_round    <= 4'(NR - 1);
                        r_rk_idx   <= RK_IDX_W'(NR - 1);
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_fsm      <= ROUND;
                    end
                end
                ROUND: begin
                    r_state <= w_round_out;
                    r_round <= r_round - 4'd1;
                    if (r_round <= 4'd1) begin
                        r_rk_idx <= '0;
                        r_fsm    <= FINAL;
                    end else begin
                        r_rk_idx <= r_round - 4'd1;
                    end
                end
                FINAL: begin
                    r_state     <= w_round_out;
                    r_rk_idx    <= RK_LAST;
                    r_out_valid <= 1'b1;
                    r_fsm       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_fsm       <= IDLE;
                    end
                end
                default: begin
                    r_fsm       <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_rk_idx    <= RK_LAST;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_state;
    assign busy      = r_busy;
    assign rk_idx    = r_rk_idx;

`ifdef AES_DEC_BLK_CNT_EN
    logic [31:0] r_blk_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk_cnt <= 32'd0;
        end else if (r_out_valid && out_ready) begin
            r_blk_cnt <= r_blk_cnt + 32'd1;
        end
    end

    assign blk_cnt = r_blk_cnt;
`endif

endmodule
